decode_ctrl_pipe: RTL and testbench
===================================

// Module: decode_ctrl_pipe
// PURPOSE
//  Registered, parametrised main-decode stage for the pipelined RV32I core; replaces the combinational opcode decoder.
//  Accepts one instruction per cycle on a valid/ready handshake and decodes the full RV32I base opcode set (load,
//  store, R, I-ALU, branch, JAL, JALR, LUI, AUIPC) into control fields. Holds the fields in a one-entry output
//  register, detects load-use hazards against the held entry, inserts bubbles and counts them.
// PARAMETERS
//  ENABLE_JUMP   1   1: decode JAL/JALR; 0: JAL/JALR flagged illegal
//  ENABLE_UTYPE  1   1: decode LUI/AUIPC; 0: LUI/AUIPC flagged illegal
//  LOADUSE_STALL 1   1: load-use bubble insertion enabled; 0: hazard check tied off
//  STALL_CNT_W   16  width of the saturating bubble counter
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  in_valid    in   1   instr is valid
//  in_ready    out  1   stage accepts instr this cycle
//  instr       in   32  instruction word
//  flush       in   1   synchronous kill of held entry (branch redirect)
//  out_valid   out  1   control fields below are valid
//  out_ready   in   1   execute stage consumes the entry
//  RegWrite    out  1   write rd
//  MemWrite    out  1   store
//  Branch      out  1   conditional branch
//  Jump        out  1   JAL/JALR
//  ALUSrc      out  1   0: rs2, 1: immediate
//  ALUASrc     out  2   00: rs1, 01: PC, 10: zero
//  ImmSrc      out  3   000 I, 001 S, 010 B, 011 J, 100 U
//  ResultSrc   out  2   00 ALU, 01 memory, 10 PC+4
//  ALUOp       out  2   00 add, 01 sub/compare, 10 R-type funct, 11 I-type funct
//  illegal     out  1   unsupported or disabled opcode
//  rd          out  5   instr[11:7] of the held entry
//  stall_cnt   out  STALL_CNT_W   bubbles inserted since reset, saturating
// BEHAVIOUR
//  - Reset: out_valid=0, all control outputs=0, rd=0, stall_cnt=0. in_ready is combinational, so it is 1 while rst=1.
//  - Decode table by opcode. Fields not listed are 0.
//      load 0000011: RegWrite, ALUSrc, ResultSrc=01, ImmSrc=000
//      store 0100011: MemWrite, ALUSrc, ImmSrc=001
//      R 0110011: RegWrite, ALUOp=10
//      I-ALU 0010011: RegWrite, ALUSrc, ALUOp=11
//      branch 1100011: Branch, ImmSrc=010, ALUOp=01
//      JAL 1101111: RegWrite, Jump, ImmSrc=011, ResultSrc=10, ALUASrc=01, ALUSrc
//      JALR 1100111: RegWrite, Jump, ALUSrc, ResultSrc=10
//      LUI 0110111: RegWrite, ALUSrc, ALUASrc=10, ImmSrc=100
//      AUIPC 0010111: RegWrite, ALUSrc, ALUASrc=01, ImmSrc=100
//      any other opcode, or an opcode disabled by its parameter: illegal=1, all other fields 0
//  - Register usage: uses_rs1 for every opcode except LUI, AUIPC and JAL. uses_rs2 for R, store and branch only.
//  - hazard = LOADUSE_STALL & out_valid & held ResultSrc==01 & rd!=0 & in_valid &
//      ((uses_rs1 & instr[19:15]==rd) | (uses_rs2 & instr[24:20]==rd)).
//  - in_ready = (~out_valid | out_ready) & ~hazard & ~flush.
//  - Transfer: when in_valid & in_ready, the decoded fields and rd are loaded on the next edge and out_valid<=1.
//  - Bubble: when out_valid & out_ready & hazard, out_valid<=0 next edge, instr is not taken, and stall_cnt increments.
//    The following cycle the hazard is clear, so the same instr is taken. Each load-use pair costs exactly one bubble.
//  - When out_valid & out_ready and there is no input transfer, out_valid<=0.
//  - When out_valid & ~out_ready, the entry and all fields hold stable. in_ready=0.
//  - Flush has priority over everything: out_valid<=0 next edge, no transfer, no stall_cnt increment. Fields may go stale.
//  - Outputs other than out_valid and stall_cnt are don't-care while out_valid=0.
//  - Held illegal entries flow like normal entries; the consumer traps on them.
//  - stall_cnt saturates at all ones and does not wrap.
//  - Latency: one cycle from accepted instr to out_valid. Throughput: one instruction per cycle with no hazards.
//  - Asserting rst mid-operation clears out_valid and stall_cnt immediately. The in-flight entry is lost.
// TESTING
//  - Reset, then add x3,x1,x2 (0x002081B3) with out_ready=1 -> next cycle out_valid=1, RegWrite=1, ALUOp=10,
//    ALUSrc=0, rd=3.
//  - lw x5,0(x1) then add x6,x5,x2 back-to-back, out_ready=1 -> one bubble (out_valid=0 for one cycle),
//    add emitted the cycle after, stall_cnt=1. Repeat with rd=x0 -> no bubble.
//  - Stream of lui, auipc, jal, jalr, sw, beq -> fields exactly per the decode table.
//    With ENABLE_JUMP=0, jal/jalr give illegal=1 and RegWrite=0.
//  - Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, held fields stable, instr accepted on the cycle
//    out_ready returns to 1.
//  - Assert flush together with in_valid=1 -> out_valid=0 next cycle, instr not accepted, stall_cnt unchanged.
//  - STALL_CNT_W=2 with 5 load-use pairs -> stall_cnt=3 (saturated). Assert rst mid-stream -> out_valid=0 and
//    stall_cnt=0 immediately.

Source files
------------

// File: rtl/decode_ctrl_pipe.sv
// rtl/decode_ctrl_pipe.sv - registered RV32I main decode stage with load-use bubble insertion
module decode_ctrl_pipe #(
  parameter bit          ENABLE_JUMP   = 1'b1,
  parameter bit          ENABLE_UTYPE  = 1'b1,
  parameter bit          LOADUSE_STALL = 1'b1,
  parameter int unsigned STALL_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            instr,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   RegWrite,
  output logic                   MemWrite,
  output logic                   Branch,
  output logic                   Jump,
  output logic                   ALUSrc,
  output logic [1:0]             ALUASrc,
  output logic [2:0]             ImmSrc,
  output logic [1:0]             ResultSrc,
  output logic [1:0]             ALUOp,
  output logic                   illegal,
  output logic [4:0]             rd,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [6:0] w_opcode;
  logic       w_reg_write, w_mem_write, w_branch, w_jump, w_alu_src, w_illegal;
  logic [1:0] w_alu_a_src, w_result_src, w_alu_op;
  logic [2:0] w_imm_src;
  logic       w_uses_rs1, w_uses_rs2, w_hazard, w_take, w_bubble;
  logic       w_unused;

  logic                   r_valid;
  logic                   r_reg_write, r_mem_write, r_branch, r_jump, r_alu_src, r_illegal;
  logic [1:0]             r_alu_a_src, r_result_src, r_alu_op;
  logic [2:0]             r_imm_src;
  logic [4:0]             r_rd;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  assign w_opcode = instr[6:0];
  // funct fields are consumed downstream, not by the main decoder
  assign w_unused = ^{instr[31:25], instr[14:12]};

  // opcode to control-field decode; disabled or unknown opcodes become illegal with zero fields
  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_alu_src    = 1'b0;
    w_alu_a_src  = 2'b00;
    w_imm_src    = 3'b000;
    w_result_src = 2'b00;
    w_alu_op     = 2'b00;
    w_illegal    = 1'b0;
    case (w_opcode)
      OP_LOAD:  begin w_reg_write = 1'b1; w_alu_src = 1'b1; w_result_src = 2'b01; end
      OP_STORE: begin w_mem_write = 1'b1; w_alu_src = 1'b1; w_imm_src = 3'b001; end
      OP_R:     begin w_reg_write = 1'b1; w_alu_op = 2'b10; end
      OP_I:     begin w_reg_write = 1'b1; w_alu_src = 1'b1; w_alu_op = 2'b11; end
      OP_BR:    begin w_branch = 1'b1; w_imm_src = 3'b010; w_alu_op = 2'b01; end
      OP_JAL: begin
        if (ENABLE_JUMP) begin
          w_reg_write = 1'b1; w_jump = 1'b1; w_imm_src = 3'b011;
          w_result_src = 2'b10; w_alu_a_src = 2'b01; w_alu_src = 1'b1;
        end else w_illegal = 1'b1;
      end
      OP_JALR: begin
        if (ENABLE_JUMP) begin
          w_reg_write = 1'b1; w_jump = 1'b1; w_alu_src = 1'b1; w_result_src = 2'b10;
        end else w_illegal = 1'b1;
      end
      OP_LUI: begin
        if (ENABLE_UTYPE) begin
          w_reg_write = 1'b1; w_alu_src = 1'b1; w_alu_a_src = 2'b10; w_imm_src = 3'b100;
        end else w_illegal = 1'b1;
      end
      OP_AUIPC: begin
        if (ENABLE_UTYPE) begin
          w_reg_write = 1'b1; w_alu_src = 1'b1; w_alu_a_src = 2'b01; w_imm_src = 3'b100;
        end else w_illegal = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // register-use is a property of the opcode alone, so disabled jumps still read rs1 for JALR
  assign w_uses_rs1 = !(w_opcode == OP_LUI || w_opcode == OP_AUIPC || w_opcode == OP_JAL);
  assign w_uses_rs2 = (w_opcode == OP_R) || (w_opcode == OP_STORE) || (w_opcode == OP_BR);

  assign w_hazard = LOADUSE_STALL && r_valid && (r_result_src == 2'b01) && (r_rd != 5'd0) &&
                    in_valid && ((w_uses_rs1 && (instr[19:15] == r_rd)) ||
                                 (w_uses_rs2 && (instr[24:20] == r_rd)));

  assign in_ready = (!r_valid || out_ready) && !w_hazard && !flush;
  assign w_take   = in_valid && in_ready;
  assign w_bubble = r_valid && out_ready && w_hazard;

  // one-entry output register; flush kills the entry, a consumed entry without refill empties it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_branch     <= 1'b0;
      r_jump       <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_a_src  <= 2'b00;
      r_imm_src    <= 3'b000;
      r_result_src <= 2'b00;
      r_alu_op     <= 2'b00;
      r_illegal    <= 1'b0;
      r_rd         <= 5'd0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_take) begin
      r_valid      <= 1'b1;
      r_reg_write  <= w_reg_write;
      r_mem_write  <= w_mem_write;
      r_branch     <= w_branch;
      r_jump       <= w_jump;
      r_alu_src    <= w_alu_src;
      r_alu_a_src  <= w_alu_a_src;
      r_imm_src    <= w_imm_src;
      r_result_src <= w_result_src;
      r_alu_op     <= w_alu_op;
      r_illegal    <= w_illegal;
      r_rd         <= instr[11:7];
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // saturating count of load-use bubbles; a flushed cycle never counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (!flush && w_bubble && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign out_valid = r_valid;
  assign RegWrite  = r_reg_write;
  assign MemWrite  = r_mem_write;
  assign Branch    = r_branch;
  assign Jump      = r_jump;
  assign ALUSrc    = r_alu_src;
  assign ALUASrc   = r_alu_a_src;
  assign ImmSrc    = r_imm_src;
  assign ResultSrc = r_result_src;
  assign ALUOp     = r_alu_op;
  assign illegal   = r_illegal;
  assign rd        = r_rd;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb/tb_decode_ctrl_pipe.sv - scoreboard bench for decode_ctrl_pipe (default and no-jump/2-bit-counter builds)
module tb_decode_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] instr = 32'd0;

  logic        in_ready_a, out_valid_a, rw_a, mw_a, br_a, j_a, as_a, ill_a;
  logic [1:0]  aa_a, rs_a, op_a;
  logic [2:0]  is_a;
  logic [4:0]  rd_a;
  logic [15:0] sc_a;

  logic        in_ready_b, out_valid_b, rw_b, mw_b, br_b, j_b, as_b, ill_b;
  logic [1:0]  aa_b, rs_b, op_b;
  logic [2:0]  is_b;
  logic [4:0]  rd_b;
  logic [1:0]  sc_b;

  int checks = 0;
  int errors = 0;

  logic [19:0] q_a[$];
  logic [19:0] q_b[$];

  // control word layout: RegWrite MemWrite Branch Jump ALUSrc ALUASrc ImmSrc ResultSrc ALUOp illegal
  localparam logic [14:0] C_R     = 15'b1_0_0_0_0_00_000_00_10_0;
  localparam logic [14:0] C_LOAD  = 15'b1_0_0_0_1_00_000_01_00_0;
  localparam logic [14:0] C_STORE = 15'b0_1_0_0_1_00_001_00_00_0;
  localparam logic [14:0] C_I     = 15'b1_0_0_0_1_00_000_00_11_0;
  localparam logic [14:0] C_BR    = 15'b0_0_1_0_0_00_010_00_01_0;
  localparam logic [14:0] C_JAL   = 15'b1_0_0_1_1_01_011_10_00_0;
  localparam logic [14:0] C_JALR  = 15'b1_0_0_1_1_00_000_10_00_0;
  localparam logic [14:0] C_LUI   = 15'b1_0_0_0_1_10_100_00_00_0;
  localparam logic [14:0] C_AUIPC = 15'b1_0_0_0_1_01_100_00_00_0;
  localparam logic [14:0] C_ILL   = 15'b0_0_0_0_0_00_000_00_00_1;

  localparam logic [31:0] ADD3   = 32'h002081B3;
  localparam logic [31:0] LW5    = 32'h0000A283;
  localparam logic [31:0] ADD6   = 32'h00228333;
  localparam logic [31:0] LW0    = 32'h0000A003;
  localparam logic [31:0] ADDX0  = 32'h00200333;
  localparam logic [31:0] SW5    = 32'h0050A023;
  localparam logic [31:0] LUI5   = 32'h123452B7;
  localparam logic [31:0] LUI7   = 32'h123453B7;
  localparam logic [31:0] AUIPC8 = 32'h00001417;
  localparam logic [31:0] JAL1   = 32'h000000EF;
  localparam logic [31:0] JALR2  = 32'h00008167;
  localparam logic [31:0] SW2    = 32'h0020A023;
  localparam logic [31:0] BEQ    = 32'h00208063;
  localparam logic [31:0] ADDI9  = 32'h00500493;
  localparam logic [31:0] BAD    = 32'hFFFFFFFF;

  logic [19:0] got_a, got_b;
  assign got_a = {rw_a, mw_a, br_a, j_a, as_a, aa_a, is_a, rs_a, op_a, ill_a, rd_a};
  assign got_b = {rw_b, mw_b, br_b, j_b, as_b, aa_b, is_b, rs_b, op_b, ill_b, rd_b};

  decode_ctrl_pipe u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .instr(instr),
    .flush(flush), .out_valid(out_valid_a), .out_ready(out_ready),
    .RegWrite(rw_a), .MemWrite(mw_a), .Branch(br_a), .Jump(j_a), .ALUSrc(as_a),
    .ALUASrc(aa_a), .ImmSrc(is_a), .ResultSrc(rs_a), .ALUOp(op_a), .illegal(ill_a),
    .rd(rd_a), .stall_cnt(sc_a)
  );

  decode_ctrl_pipe #(.ENABLE_JUMP(1'b0), .STALL_CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .instr(instr),
    .flush(flush), .out_valid(out_valid_b), .out_ready(out_ready),
    .RegWrite(rw_b), .MemWrite(mw_b), .Branch(br_b), .Jump(j_b), .ALUSrc(as_b),
    .ALUASrc(aa_b), .ImmSrc(is_b), .ResultSrc(rs_b), .ALUOp(op_b), .illegal(ill_b),
    .rd(rd_b), .stall_cnt(sc_b)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] pk(input logic [14:0] c, input logic [4:0] r);
    return {c, r};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // monitor for build A: a flushed entry is dropped, a consumed entry is compared
  always @(negedge clk) begin
    if (!rst && out_valid_a) begin
      if (flush) begin
        if (q_a.size() > 0) q_a.delete(0);
      end else if (out_ready) begin
        checks++;
        if (q_a.size() == 0) begin
          errors++;
          $display("FAIL mon_a: unexpected entry got %h expected none", got_a);
        end else begin
          if (got_a !== q_a[0]) begin
            errors++;
            $display("FAIL mon_a: got %h expected %h", got_a, q_a[0]);
          end
          q_a.delete(0);
        end
      end
    end
  end

  // monitor for build B
  always @(negedge clk) begin
    if (!rst && out_valid_b) begin
      if (flush) begin
        if (q_b.size() > 0) q_b.delete(0);
      end else if (out_ready) begin
        checks++;
        if (q_b.size() == 0) begin
          errors++;
          $display("FAIL mon_b: unexpected entry got %h expected none", got_b);
        end else begin
          if (got_b !== q_b[0]) begin
            errors++;
            $display("FAIL mon_b: got %h expected %h", got_b, q_b[0]);
          end
          q_b.delete(0);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // present one instr until accepted; the number of refused cycles must match exp_waits
  task automatic send(input logic [31:0] ins, input logic [19:0] e_a, input logic [19:0] e_b,
                      input int exp_waits, input string nm);
    int  waits;
    bit  done;
    waits = 0;
    done  = 1'b0;
    in_valid = 1'b1;
    instr    = ins;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (in_ready_a) begin
        q_a.push_back(e_a);
        q_b.push_back(e_b);
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk({nm, " waits"}, waits, exp_waits);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst out_valid_a", out_valid_a, 0);
    chk("rst out_valid_b", out_valid_b, 0);
    chk("rst fields_a", got_a, 0);
    chk("rst stall_a", sc_a, 0);
    chk("rst stall_b", sc_b, 0);
    chk("rst in_ready", in_ready_a, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single add, one-cycle latency
    send(ADD3, pk(C_R, 3), pk(C_R, 3), 0, "add3");
    @(negedge clk);
    chk("latency out_valid", out_valid_a, 1);
    @(posedge clk);
    #1;

    // load-use pair costs one bubble
    send(LW5, pk(C_LOAD, 5), pk(C_LOAD, 5), 0, "lw5");
    send(ADD6, pk(C_R, 6), pk(C_R, 6), 1, "add6 after lw5");
    @(negedge clk);
    chk("stall after pair a", sc_a, 1);
    chk("stall after pair b", sc_b, 1);
    @(posedge clk);
    #1;

    // load to x0 never stalls
    send(LW0, pk(C_LOAD, 0), pk(C_LOAD, 0), 0, "lw0");
    send(ADDX0, pk(C_R, 6), pk(C_R, 6), 0, "add using x0");

    // decode stream
    send(LUI7,   pk(C_LUI, 7),   pk(C_LUI, 7),   0, "lui");
    send(AUIPC8, pk(C_AUIPC, 8), pk(C_AUIPC, 8), 0, "auipc");
    send(JAL1,   pk(C_JAL, 1),   pk(C_ILL, 1),   0, "jal");
    send(JALR2,  pk(C_JALR, 2),  pk(C_ILL, 2),   0, "jalr");
    send(SW2,    pk(C_STORE, 0), pk(C_STORE, 0), 0, "sw");
    send(BEQ,    pk(C_BR, 0),    pk(C_BR, 0),    0, "beq");
    send(ADDI9,  pk(C_I, 9),     pk(C_I, 9),     0, "addi");
    send(BAD,    pk(C_ILL, 31),  pk(C_ILL, 31),  0, "bad opcode");

    // rs2 hazard through a store, and no hazard into lui
    send(LW5, pk(C_LOAD, 5), pk(C_LOAD, 5), 0, "lw5 b");
    send(SW5, pk(C_STORE, 0), pk(C_STORE, 0), 1, "sw after lw5");
    send(LW5, pk(C_LOAD, 5), pk(C_LOAD, 5), 0, "lw5 c");
    send(LUI5, pk(C_LUI, 5), pk(C_LUI, 5), 0, "lui after lw5");

    // back-pressure: held entry stays stable for three cycles
    idle(1);
    out_ready = 1'b0;
    send(ADDI9, pk(C_I, 9), pk(C_I, 9), 0, "addi held");
    in_valid = 1'b1;
    instr    = ADD3;
    repeat (3) begin
      @(negedge clk);
      chk("hold in_ready", in_ready_a, 0);
      chk("hold out_valid", out_valid_a, 1);
      chk("hold fields", got_a, pk(C_I, 9));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(ADD3, pk(C_R, 3), pk(C_R, 3), 0, "add after hold");

    // flush while idle blocks the transfer
    idle(2);
    flush    = 1'b1;
    in_valid = 1'b1;
    instr    = ADD3;
    @(negedge clk);
    chk("flush in_ready", in_ready_a, 0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush idle out_valid", out_valid_a, 0);
    chk("flush idle stall", sc_a, 2);
    @(posedge clk);
    #1;

    // flush over a pending load-use bubble: entry dropped, no count
    send(LW5, pk(C_LOAD, 5), pk(C_LOAD, 5), 0, "lw5 flushed");
    flush    = 1'b1;
    in_valid = 1'b1;
    instr    = ADD6;
    @(negedge clk);
    chk("flush hazard in_ready", in_ready_a, 0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush held out_valid", out_valid_a, 0);
    chk("flush held stall_a", sc_a, 2);
    chk("flush held stall_b", sc_b, 2);
    @(posedge clk);
    #1;

    // five more load-use pairs: 2-bit counter saturates
    for (int p = 0; p < 5; p++) begin
      send(LW5, pk(C_LOAD, 5), pk(C_LOAD, 5), 0, "sat lw5");
      send(ADD6, pk(C_R, 6), pk(C_R, 6), 1, "sat add6");
    end
    idle(2);
    @(negedge clk);
    chk("sat stall_a", sc_a, 7);
    chk("sat stall_b", sc_b, 3);
    @(posedge clk);
    #1;

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    send(LW5, pk(C_LOAD, 5), pk(C_LOAD, 5), 0, "lw5 before rst");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst out_valid_a", out_valid_a, 0);
    chk("async rst out_valid_b", out_valid_b, 0);
    chk("async rst stall_a", sc_a, 0);
    chk("async rst stall_b", sc_b, 0);
    q_a.delete();
    q_b.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    idle(2);
    chk("queue a drained", q_a.size(), 0);
    chk("queue b drained", q_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // hard bound on run time
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
